// File: rtl/spram_arbiter_pkg.sv
// Shared types and default widths for the single-port RAM arbiter.
// Holds the read-path FSM encoding used by spram_port_arbiter.
package spram_arbiter_pkg;

  localparam int DEF_ADDR_WIDTH = 14;
  localparam int DEF_DATA_WIDTH = 16;
  localparam int DEF_MASK_WIDTH = 4;

  // Read path: idle, RAM read driven, RAM data captured, response waiting.
  typedef enum logic [1:0] {
    IDLE       = 2'd0,
    RD_ISSUE   = 2'd1,
    RD_CAPTURE = 2'd2,
    RESP_HOLD  = 2'd3
  } rd_state_e;

endpackage

// File: rtl/rr_arbiter2.sv
// Two-way write/read grant with round-robin tie-break and optional write priority.
// Grants are combinational; the last-grant flag moves only on an accepted request.
module rr_arbiter2 #(
  parameter int WRITE_PRIORITY = 0
) (
  input  logic clk,
  input  logic reset,
  input  logic wr_valid,
  input  logic rd_valid,
  input  logic rd_eligible,
  output logic wr_grant,
  output logic rd_grant
);

  logic last_rd;
  logic wr_wins_tie;

  // With both or neither requesting, the tie winner holds the single ready.
  always_comb begin
    // NOTE: every output gets a default before the branches, so no path leaves a latch.
    wr_grant    = 1'b0;
    rd_grant    = 1'b0;
    wr_wins_tie = (WRITE_PRIORITY != 0) ? 1'b1 : last_rd;
    if (!reset) begin
      wr_grant = 1'b0;
    end else if (!rd_eligible) begin
      wr_grant = 1'b1;
    end else if (wr_valid != rd_valid) begin
      wr_grant = wr_valid;
      rd_grant = rd_valid;
    end else begin
      wr_grant = wr_wins_tie;
      rd_grant = !wr_wins_tie;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      last_rd <= 1'b1;
    end else if (wr_grant && wr_valid) begin
      last_rd <= 1'b0;
    end else if (rd_grant && rd_valid) begin
      last_rd <= 1'b1;
    end
  end

endmodule

// File: rtl/spram_port_arbiter.sv
// Shares one single-port RAM between a write channel and a read channel
// with a held read-response register; one RAM operation per cycle.
module spram_port_arbiter
  import spram_arbiter_pkg::*;
#(
  parameter int ADDR_WIDTH     = DEF_ADDR_WIDTH,
  parameter int DATA_WIDTH     = DEF_DATA_WIDTH,
  parameter int MASK_WIDTH     = DEF_MASK_WIDTH,
  parameter int WRITE_PRIORITY = 0
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  wr_valid,
  output logic                  wr_ready,
  input  logic [ADDR_WIDTH-1:0] wr_addr,
  input  logic [DATA_WIDTH-1:0] wr_data,
  input  logic [MASK_WIDTH-1:0] wr_mask,
  input  logic                  rd_valid,
  output logic                  rd_ready,
  input  logic [ADDR_WIDTH-1:0] rd_addr,
  output logic                  rd_resp_valid,
  input  logic                  rd_resp_ready,
  output logic [DATA_WIDTH-1:0] rd_resp_data,
  output logic                  ram_cs,
  output logic                  ram_write,
  output logic [ADDR_WIDTH-1:0] ram_addr,
  output logic [DATA_WIDTH-1:0] ram_wdata,
  output logic [MASK_WIDTH-1:0] ram_mask,
  input  logic [DATA_WIDTH-1:0] ram_rdata
);

  rd_state_e state;
  logic      rd_eligible;
  logic      wr_acc;
  logic      rd_acc;

  // A new read may start as the held response leaves in the same cycle.
  assign rd_eligible = (state == IDLE) || ((state == RESP_HOLD) && rd_resp_ready);
  assign wr_acc      = wr_valid && wr_ready;
  assign rd_acc      = rd_valid && rd_ready;

  rr_arbiter2 #(
    .WRITE_PRIORITY(WRITE_PRIORITY)
  ) u_arb (
    .clk        (clk),
    .reset      (reset),
    .wr_valid   (wr_valid),
    .rd_valid   (rd_valid),
    .rd_eligible(rd_eligible),
    .wr_grant   (wr_ready),
    .rd_grant   (rd_ready)
  );

  always_ff @(posedge clk or negedge reset) begin
    // NOTE: sequential state uses nonblocking assignment so every flop samples pre-edge values.
    if (!reset) begin
      ram_cs    <= 1'b0;
      ram_write <= 1'b0;
      ram_addr  <= '0;
      ram_wdata <= '0;
      ram_mask  <= '0;
    end else begin
      ram_cs    <= wr_acc || rd_acc;
      ram_write <= wr_acc;
      if (wr_acc) begin
        ram_addr  <= wr_addr;
        ram_wdata <= wr_data;
        ram_mask  <= wr_mask;
      end else if (rd_acc) begin
        ram_addr <= rd_addr;
        ram_mask <= '0;
      end
    end
  end

  // RAM data is valid the cycle after RD_ISSUE, so it is captured in RD_CAPTURE.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state         <= IDLE;
      rd_resp_valid <= 1'b0;
      rd_resp_data  <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (rd_acc) state <= RD_ISSUE;
        end
        RD_ISSUE: begin
          state <= RD_CAPTURE;
        end
        RD_CAPTURE: begin
          state         <= RESP_HOLD;
          rd_resp_valid <= 1'b1;
          rd_resp_data  <= ram_rdata;
        end
        RESP_HOLD: begin
          if (rd_resp_ready) begin
            rd_resp_valid <= 1'b0;
            state         <= rd_acc ? RD_ISSUE : IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_spram_port_arbiter.sv
// Self-checking bench: transaction-level model of grants, RAM commands and
// read responses, driven by directed scenarios plus randomized traffic.
module tb_spram_port_arbiter;

  logic        clk;
  logic        reset;
  logic        wr_valid, wr_ready, rd_valid, rd_ready;
  logic [13:0] wr_addr, rd_addr;
  logic [15:0] wr_data;
  logic [3:0]  wr_mask;
  logic        rd_resp_valid, rd_resp_ready;
  logic [15:0] rd_resp_data;
  logic        ram_cs, ram_write;
  logic [13:0] ram_addr;
  logic [15:0] ram_wdata, ram_rdata;
  logic [3:0]  ram_mask;

  // Second instance with write priority; only its grants are observed.
  logic        wp_wr_valid, wp_wr_ready, wp_rd_valid, wp_rd_ready;
  logic        wp_resp_valid, wp_cs, wp_write;
  logic [15:0] wp_resp_data, wp_wdata;
  logic [13:0] wp_addr;
  logic [3:0]  wp_mask;

  int n_checks = 0;
  int n_pass   = 0;

  spram_port_arbiter #(.WRITE_PRIORITY(0)) dut (
    .clk(clk), .reset(reset),
    .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_addr(wr_addr), .wr_data(wr_data), .wr_mask(wr_mask),
    .rd_valid(rd_valid), .rd_ready(rd_ready), .rd_addr(rd_addr),
    .rd_resp_valid(rd_resp_valid), .rd_resp_ready(rd_resp_ready), .rd_resp_data(rd_resp_data),
    .ram_cs(ram_cs), .ram_write(ram_write), .ram_addr(ram_addr), .ram_wdata(ram_wdata),
    .ram_mask(ram_mask), .ram_rdata(ram_rdata)
  );

  spram_port_arbiter #(.WRITE_PRIORITY(1)) dut_wp (
    .clk(clk), .reset(reset),
    .wr_valid(wp_wr_valid), .wr_ready(wp_wr_ready), .wr_addr(14'h0), .wr_data(16'h0), .wr_mask(4'h0),
    .rd_valid(wp_rd_valid), .rd_ready(wp_rd_ready), .rd_addr(14'h0),
    .rd_resp_valid(wp_resp_valid), .rd_resp_ready(1'b1), .rd_resp_data(wp_resp_data),
    .ram_cs(wp_cs), .ram_write(wp_write), .ram_addr(wp_addr), .ram_wdata(wp_wdata),
    .ram_mask(wp_mask), .ram_rdata(16'h0)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Single-port RAM with registered read and nibble write mask.
  logic [15:0] mem [0:16383];
  initial begin
    for (int i = 0; i < 16384; i++) mem[i] = 16'h0;
    ram_rdata = 16'h0;
  end
  always @(posedge clk) begin
    if (ram_cs) begin
      if (ram_write) begin
        for (int i = 0; i < 4; i++)
          if (ram_mask[i]) mem[ram_addr][4*i +: 4] <= ram_wdata[4*i +: 4];
      end else begin
        ram_rdata <= mem[ram_addr];
      end
    end
  end

  // ---------------- reference model ----------------
  logic [15:0] exp_mem [int];
  int          rd_cnt;
  logic        m_resp_valid, m_last_rd, m_cs, m_write;
  logic [15:0] m_resp_data, pend_data, m_wdata;
  logic [13:0] m_addr;
  logic [3:0]  m_mask;
  int          wr_count = 0;
  int          rd_count = 0;

  function automatic logic [15:0] mem_value(input int a);
    return exp_mem.exists(a) ? exp_mem[a] : 16'h0;
  endfunction

  function automatic logic [15:0] merge(input logic [15:0] old, input logic [15:0] data,
                                        input logic [3:0] mask);
    logic [15:0] r;
    r = old;
    for (int i = 0; i < 4; i++) if (mask[i]) r[4*i +: 4] = data[4*i +: 4];
    return r;
  endfunction

  task automatic model_reset();
    rd_cnt       = 0;
    m_resp_valid = 1'b0;
    m_resp_data  = 16'h0;
    pend_data    = 16'h0;
    m_last_rd    = 1'b1;
    m_cs         = 1'b0;
    m_write      = 1'b0;
    m_addr       = 14'h0;
    m_wdata      = 16'h0;
    m_mask       = 4'h0;
  endtask

  // One clock: inputs already driven at the preceding negedge. Checks readies
  // just before the edge and registered outputs 1 ns after it.
  task automatic tick(input string tag);
    logic elig, ew, er, w_acc, r_acc;
    #4;
    elig = (rd_cnt == 0) && (!m_resp_valid || rd_resp_ready);
    if (!elig)                       begin ew = 1'b1;      er = 1'b0;       end
    else if (wr_valid && !rd_valid)  begin ew = 1'b1;      er = 1'b0;       end
    else if (rd_valid && !wr_valid)  begin ew = 1'b0;      er = 1'b1;       end
    else                             begin ew = m_last_rd; er = !m_last_rd; end
    n_checks++;
    if (wr_ready !== ew) $display("FAIL %s wr_ready: got %b expected %b", tag, wr_ready, ew);
    else n_pass++;
    n_checks++;
    if (rd_ready !== er) $display("FAIL %s rd_ready: got %b expected %b", tag, rd_ready, er);
    else n_pass++;
    w_acc = wr_valid && ew;
    r_acc = rd_valid && er;
    if (m_resp_valid && rd_resp_ready) m_resp_valid = 1'b0;
    if (rd_cnt > 0) begin
      rd_cnt--;
      if (rd_cnt == 0) begin
        m_resp_valid = 1'b1;
        m_resp_data  = pend_data;
      end
    end
    m_cs    = w_acc || r_acc;
    m_write = w_acc;
    if (w_acc) begin
      exp_mem[int'(wr_addr)] = merge(mem_value(int'(wr_addr)), wr_data, wr_mask);
      m_addr = wr_addr; m_wdata = wr_data; m_mask = wr_mask; m_last_rd = 1'b0;
      wr_count++;
    end else if (r_acc) begin
      pend_data = mem_value(int'(rd_addr));
      rd_cnt = 2;
      m_addr = rd_addr; m_mask = 4'h0; m_last_rd = 1'b1;
      rd_count++;
    end
    @(posedge clk);
    #1;
    n_checks++;
    if ({ram_cs, ram_write} !== {m_cs, m_write})
      $display("FAIL %s ram_cs/write: got %b%b expected %b%b", tag, ram_cs, ram_write, m_cs, m_write);
    else n_pass++;
    n_checks++;
    if ({ram_addr, ram_wdata, ram_mask} !== {m_addr, m_wdata, m_mask})
      $display("FAIL %s ram addr/wdata/mask: got %h/%h/%h expected %h/%h/%h", tag,
               ram_addr, ram_wdata, ram_mask, m_addr, m_wdata, m_mask);
    else n_pass++;
    n_checks++;
    if (rd_resp_valid !== m_resp_valid)
      $display("FAIL %s rd_resp_valid: got %b expected %b", tag, rd_resp_valid, m_resp_valid);
    else n_pass++;
    if (m_resp_valid) begin
      n_checks++;
      if (rd_resp_data !== m_resp_data)
        $display("FAIL %s rd_resp_data: got %h expected %h", tag, rd_resp_data, m_resp_data);
      else n_pass++;
    end
    @(negedge clk);
  endtask

  task automatic idle(input int n, input logic resp_ready);
    wr_valid = 1'b0; rd_valid = 1'b0; rd_resp_ready = resp_ready;
    for (int i = 0; i < n; i++) tick("idle");
  endtask

  task automatic drive_write(input logic [13:0] a, input logic [15:0] d, input logic [3:0] m);
    wr_valid = 1'b1; wr_addr = a; wr_data = d; wr_mask = m;
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    n_checks++;
    if ({wr_ready, rd_ready, rd_resp_valid, ram_cs, ram_write} !== 5'b0)
      $display("FAIL reset controls: got %b expected 00000",
               {wr_ready, rd_ready, rd_resp_valid, ram_cs, ram_write});
    else n_pass++;
    n_checks++;
    if ({ram_addr, ram_wdata, ram_mask, rd_resp_data} !== 50'h0)
      $display("FAIL reset buses: got %h expected 0", {ram_addr, ram_wdata, ram_mask, rd_resp_data});
    else n_pass++;
    reset = 1'b1;
    model_reset();
    idle(2, 1'b0);
  endtask

  task automatic test_write_read();
    drive_write(14'h0010, 16'hBEEF, 4'hF);
    rd_valid = 1'b0; rd_resp_ready = 1'b0;
    tick("wr_beef");
    n_checks++;
    if ({ram_cs, ram_write, ram_addr} !== {2'b11, 14'h0010})
      $display("FAIL wr_cmd: got %b%b %h expected 11 0010", ram_cs, ram_write, ram_addr);
    else n_pass++;
    wr_valid = 1'b0; rd_valid = 1'b1; rd_addr = 14'h0010;
    tick("rd_beef");
    rd_valid = 1'b0;
    tick("rd_wait1");
    n_checks++;
    if (rd_resp_valid !== 1'b0) $display("FAIL rd_early: got %b expected 0", rd_resp_valid);
    else n_pass++;
    tick("rd_wait2");
    n_checks++;
    if ({rd_resp_valid, rd_resp_data} !== {1'b1, 16'hBEEF})
      $display("FAIL rd_beef_data: got %b %h expected 1 beef", rd_resp_valid, rd_resp_data);
    else n_pass++;
    idle(1, 1'b1);
  endtask

  task automatic test_masked_write();
    rd_valid = 1'b0; rd_resp_ready = 1'b0;
    drive_write(14'h0005, 16'h1234, 4'hF); tick("mask_full");
    drive_write(14'h0005, 16'h0AAA, 4'h1); tick("mask_nib0");
    wr_valid = 1'b0; rd_valid = 1'b1; rd_addr = 14'h0005;
    tick("mask_rd");
    idle(2, 1'b0);
    n_checks++;
    if (rd_resp_data !== 16'h123A) $display("FAIL masked_data: got %h expected 123a", rd_resp_data);
    else n_pass++;
    idle(1, 1'b1);
  endtask

  task automatic test_contention();
    int w0, r0, wc, rc;
    w0 = wr_count; r0 = rd_count;
    rd_resp_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      drive_write(14'h0100 + 14'($urandom_range(0, 15)), 16'($urandom), 4'hF);
      rd_valid = 1'b1; rd_addr = 14'h0100 + 14'($urandom_range(0, 15));
      tick("contend");
    end
    n_checks++;
    if ((wr_count - w0) + (rd_count - r0) != 8 || (rd_count - r0) < 2)
      $display("FAIL contend_share: got %0d writes %0d reads expected 8 total with >=2 reads",
               wr_count - w0, rd_count - r0);
    else n_pass++;
    idle(4, 1'b1);
    wc = 0; rc = 0;
    wp_wr_valid = 1'b1; wp_rd_valid = 1'b1;
    for (int i = 0; i < 8; i++) begin
      #4;
      if (wp_wr_ready) wc++;
      if (wp_rd_ready) rc++;
      @(posedge clk);
      @(negedge clk);
    end
    wp_wr_valid = 1'b0; wp_rd_valid = 1'b0;
    n_checks++;
    if (wc != 8 || rc != 0)
      $display("FAIL write_priority: got %0d writes %0d reads expected 8 writes 0 reads", wc, rc);
    else n_pass++;
  endtask

  task automatic test_backpressure();
    int w0, r0;
    rd_resp_ready = 1'b0; wr_valid = 1'b0;
    rd_valid = 1'b1; rd_addr = 14'h0010;
    tick("bp_rd");
    idle(2, 1'b0);
    w0 = wr_count;
    for (int i = 0; i < 5; i++) begin
      drive_write(14'h0300 + 14'(i), 16'($urandom), 4'($urandom));
      rd_valid = 1'b1; rd_addr = 14'h0005;
      tick("bp_hold");
      n_checks++;
      if ({rd_resp_valid, rd_resp_data} !== {1'b1, 16'hBEEF})
        $display("FAIL bp_stable: got %b %h expected 1 beef", rd_resp_valid, rd_resp_data);
      else n_pass++;
    end
    n_checks++;
    if (wr_count - w0 != 5) $display("FAIL bp_writes: got %0d expected 5", wr_count - w0);
    else n_pass++;
    r0 = rd_count;
    wr_valid = 1'b0; rd_valid = 1'b1; rd_resp_ready = 1'b1;
    tick("bp_release");
    n_checks++;
    if (rd_count - r0 != 1) $display("FAIL bp_same_cycle_read: got %0d expected 1", rd_count - r0);
    else n_pass++;
    idle(4, 1'b1);
  endtask

  task automatic test_random();
    for (int i = 0; i < 400; i++) begin
      wr_valid = 1'($urandom_range(0, 1));
      wr_addr  = 14'h0200 + 14'($urandom_range(0, 7));
      wr_data  = 16'($urandom);
      wr_mask  = 4'($urandom);
      rd_valid = 1'($urandom_range(0, 1));
      rd_addr  = 14'h0200 + 14'($urandom_range(0, 7));
      rd_resp_ready = ($urandom_range(0, 9) < 7);
      tick("random");
    end
    idle(4, 1'b1);
  endtask

  task automatic test_reset_mid_read();
    rd_resp_ready = 1'b0; wr_valid = 1'b0;
    rd_valid = 1'b1; rd_addr = 14'h0005;
    tick("mid_rd");
    rd_valid = 1'b0;
    tick("mid_issue");
    reset = 1'b0;
    #1;
    n_checks++;
    if ({wr_ready, rd_ready, rd_resp_valid, ram_cs, ram_write} !== 5'b0)
      $display("FAIL mid_reset controls: got %b expected 00000",
               {wr_ready, rd_ready, rd_resp_valid, ram_cs, ram_write});
    else n_pass++;
    n_checks++;
    if ({ram_addr, ram_wdata, ram_mask, rd_resp_data} !== 50'h0)
      $display("FAIL mid_reset buses: got %h expected 0", {ram_addr, ram_wdata, ram_mask, rd_resp_data});
    else n_pass++;
    @(negedge clk);
    reset = 1'b1;
    model_reset();
    for (int i = 0; i < 6; i++) begin
      tick("post_reset");
      n_checks++;
      if (rd_resp_valid !== 1'b0) $display("FAIL post_reset_resp: got %b expected 0", rd_resp_valid);
      else n_pass++;
    end
    rd_valid = 1'b1; rd_addr = 14'h0005;
    tick("post_reset_rd");
    idle(2, 1'b0);
    n_checks++;
    if ({rd_resp_valid, rd_resp_data} !== {1'b1, 16'h123A})
      $display("FAIL post_reset_read: got %b %h expected 1 123a", rd_resp_valid, rd_resp_data);
    else n_pass++;
    idle(1, 1'b1);
  endtask

  initial begin
    reset = 1'b0;
    wr_valid = 1'b0; wr_addr = '0; wr_data = '0; wr_mask = '0;
    rd_valid = 1'b0; rd_addr = '0; rd_resp_ready = 1'b0;
    wp_wr_valid = 1'b0; wp_rd_valid = 1'b0;
    model_reset();
    @(negedge clk);
    test_reset();
    test_write_read();
    test_masked_write();
    test_contention();
    test_backpressure();
    test_random();
    test_reset_mid_read();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/spram_port_arbiter.md
SPRAM_PORT_ARBITER -- requirements
Module: spram_port_arbiter

Interface
REQ-001 SHALL have parameter ADDR_WIDTH, default 14, the RAM word address width.
REQ-002 SHALL have parameter DATA_WIDTH, default 16, the RAM word width.
REQ-003 SHALL have parameter MASK_WIDTH, default 4, the nibble write-mask width.
REQ-004 SHALL have parameter WRITE_PRIORITY, default 0: 0 = round-robin, 1 = write always wins.
REQ-005 SHALL have ports: clk  in  1  sole clock, all logic on rising edge.
REQ-006 reset  in  1  asynchronous, active-low reset.
REQ-007 wr_valid in 1, wr_ready out 1, wr_addr in ADDR_WIDTH, wr_data in DATA_WIDTH, wr_mask in MASK_WIDTH  write request channel.
REQ-008 rd_valid in 1, rd_ready out 1, rd_addr in ADDR_WIDTH  read request channel.
REQ-009 rd_resp_valid out 1, rd_resp_ready in 1, rd_resp_data out DATA_WIDTH  read response channel.
REQ-010 ram_cs out 1, ram_write out 1, ram_addr out ADDR_WIDTH, ram_wdata out DATA_WIDTH, ram_mask out MASK_WIDTH, ram_rdata in DATA_WIDTH  single-port RAM side (one op per cycle, read data registered by RAM, valid cycle after op).

Function
REQ-011 A request SHALL be accepted on a rising edge where valid and ready are both high; payload sampled at that edge.
REQ-012 At most one of wr_ready, rd_ready SHALL be high in any cycle.
REQ-013 Read eligible only when no read outstanding and response register empty (or emptied this cycle by rd_resp_ready); otherwise rd_ready SHALL be low.
REQ-014 Write always eligible; writes SHALL proceed while a read response is held.
REQ-015 Both eligible and valid: WRITE_PRIORITY=1 grants write; WRITE_PRIORITY=0 grants the port not granted last; last-grant flag updates only on acceptance.
REQ-016 Only one valid/eligible: that port SHALL be granted the same cycle (no bubble).
REQ-017 ready SHALL not wait on valid of the same port except via REQ-015 tie-breaking.
REQ-018 Accept at edge N SHALL drive registered RAM signals during cycle N+1: ram_cs=1, ram_write=1 for write/0 for read, ram_addr, ram_wdata, ram_mask (mask 0 on reads).
REQ-019 Cycles with no acceptance SHALL drive ram_cs=0, ram_write=0; addr/data/mask hold last values.
REQ-020 Read accepted at edge N: ram_rdata captured at edge N+2, rd_resp_valid high from cycle N+3 until accepted via rd_resp_ready.
REQ-021 rd_resp_data SHALL stay stable while rd_resp_valid high and rd_resp_ready low.
REQ-022 Write then read of same address on consecutive accepts SHALL return the new data (ordering preserved by single port).
REQ-023 Internal FSM states: IDLE (no read in flight), RD_ISSUE (RAM read driven), RD_CAPTURE (capture ram_rdata), RESP_HOLD (response waiting); RESP_HOLD->IDLE on rd_resp_ready.
REQ-024 rd_resp_ready high in RESP_HOLD with rd_valid SHALL allow a new read accept the same cycle.

Reset
REQ-025 While reset low: wr_ready=0, rd_ready=0, rd_resp_valid=0, ram_cs=0, ram_write=0, ram_addr=0, ram_wdata=0, ram_mask=0, rd_resp_data=0.
REQ-026 Reset SHALL clear FSM to IDLE and last-grant flag to "read" (first tie goes to write).
REQ-027 Reset mid-read SHALL discard the outstanding read; no response emitted afterwards.

Structure
REQ-028 Shared package spram_arbiter_pkg SHALL hold FSM state enum and default width constants.
REQ-029 Grant logic SHALL be one sub-module rr_arbiter2 (2-way round-robin with priority override); remainder in spram_port_arbiter.

Verification
REQ-030 Write addr 0x0010 data 0xBEEF mask 0xF, then read 0x0010 -> ram_cs/ram_write=1 one cycle after write accept; rd_resp_data=0xBEEF 3 cycles after read accept.
REQ-031 Masked write 0x0AAA mask 0x1 over 0x1234 at addr 5, read 5 -> 0x123A.
REQ-032 wr_valid and rd_valid held high 8 cycles, WRITE_PRIORITY=0 -> grants alternate W,R,...; with rd_resp_ready=1 reads not starved; WRITE_PRIORITY=1 -> 8 writes, 0 reads.
REQ-033 rd_resp_ready held low after a read -> rd_ready stays 0, writes still accepted, rd_resp_data stable; raise rd_resp_ready -> new read accepted same cycle.
REQ-034 Assert reset one cycle after read accept -> all outputs per REQ-025; after release, rd_resp_valid stays 0 until a new read.
